// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg
//   Shared constants and types for the MIPS pipeline control blocks.
//   - Opcode / funct encodings used by the hazard logic
//   - Mult/div sequencer state enum
//   - Bit positions of the stall/flush priority request vector
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  // Opcode and funct encodings
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;

  // Mult/div sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Request-vector bit positions, highest index = highest priority:
  // memory wait beats a taken branch, which beats load-use / mult-div holds.
  localparam int PRIO_HAZ = 0;
  localparam int PRIO_BR  = 1;
  localparam int PRIO_MW  = 2;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/muldiv_seq.sv
//------------------------------------------------------------------------------
// muldiv_seq
//   Occupancy sequencer for the shared iterative multiply/divide unit.
//   Issues a one-cycle start pulse and keeps o_busy high for exactly
//   MULT_CYCLES or DIV_CYCLES cycles, then spends one cycle in DONE.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     i_is_mult/i_is_div  older instruction (ID) is mult / div
//     i_mem_wait        data memory stall; blocks issue
//     o_start           registered one-cycle start pulse
//     o_op              0 = mult, 1 = div (valid with o_start)
//     o_busy            registered, high while in MULT or DIV
//   Macro: HAZARD_CTL_DIV_EN enables divide sequencing; when undefined
//   i_is_div is ignored and o_op stays 0.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_seq
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
)(
  input  logic clk,
  input  logic reset,
  input  logic i_is_mult,
  input  logic i_is_div,
  input  logic i_mem_wait,
  output logic o_start,
  output logic o_op,
  output logic o_busy
);

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_start, w_start_nxt;
  logic             r_op, w_op_nxt;
  logic             r_busy;
  logic [CNT_W-1:0] w_mult_load;
  logic [CNT_W-1:0] w_div_load;

  assign w_mult_load = CNT_W'(MULT_CYCLES - 1);
  assign w_div_load  = CNT_W'(DIV_CYCLES - 1);

`ifndef HAZARD_CTL_DIV_EN
  logic w_unused;
  assign w_unused = &{1'b0, i_is_div, w_div_load};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_op    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= w_start_nxt;
      r_op    <= w_op_nxt;
      r_busy  <= (w_state_nxt == MD_MULT) || (w_state_nxt == MD_DIV);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = 1'b0;
    w_op_nxt    = r_op;
    case (r_state)
      MD_IDLE: begin
        if (i_is_mult && !i_mem_wait) begin
          w_state_nxt = MD_MULT;
          w_cnt_nxt   = w_mult_load;
          w_start_nxt = 1'b1;
          w_op_nxt    = 1'b0;
        end
`ifdef HAZARD_CTL_DIV_EN
        else if (i_is_div && !i_mem_wait) begin
          w_state_nxt = MD_DIV;
          w_cnt_nxt   = w_div_load;
          w_start_nxt = 1'b1;
          w_op_nxt    = 1'b1;
        end
`endif
      end
      // Loaded with N-1 and left at zero, so the busy window is exactly N
      // cycles and the counter never wraps below zero.
      MD_MULT, MD_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = MD_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  assign o_start = r_start;
  assign o_busy  = r_busy;
`ifdef HAZARD_CTL_DIV_EN
  assign o_op    = r_op;
`else
  assign o_op    = 1'b0;
`endif

endmodule : muldiv_seq

`default_nettype wire

// File: rtl/hazard_ctl.sv
//------------------------------------------------------------------------------
// hazard_ctl
//   Pipeline hazard controller beside the decode stage. Produces AnyStall,
//   flush and Bubble_EX from load-use, mult/div-busy, memory-wait and
//   taken-branch conditions, and sequences the shared mult/div unit.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     FetchData_IF[31:0]         instruction entering decode
//     MemToReg_ID, RegWrite_ID   decode controls of the older instruction
//     WriteReg_ID[4:0]           destination of the older instruction
//     IsMult_ID, IsDiv_ID        older instruction is mult / div
//     BranchTaken_EX             taken branch / jump redirect
//     DmemReady                  data memory completes this cycle
//     AnyStall, flush, Bubble_EX combinational pipeline controls
//     MulDivStart, MulDivOp, MulDivBusy  registered mult/div controls
//   Macro: HAZARD_CTL_DIV_EN enables divide sequencing and makes DIV a
//   mult/div user for the busy hazard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] FetchData_IF,
  input  logic        MemToReg_ID,
  input  logic        RegWrite_ID,
  input  logic [4:0]  WriteReg_ID,
  input  logic        IsMult_ID,
  input  logic        IsDiv_ID,
  input  logic        BranchTaken_EX,
  input  logic        DmemReady,
  output logic        AnyStall,
  output logic        flush,
  output logic        Bubble_EX,
  output logic        MulDivStart,
  output logic        MulDivOp,
  output logic        MulDivBusy
);

  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs, w_rt;
  logic       w_rtype, w_hilo_rd, w_md_user;
  logic       w_lu, w_md, w_mw;
  logic [2:0] w_req;
  logic       w_unused;

  assign w_op    = FetchData_IF[31:26];
  assign w_rs    = FetchData_IF[25:21];
  assign w_rt    = FetchData_IF[20:16];
  assign w_funct = FetchData_IF[5:0];
  assign w_unused = &{1'b0, FetchData_IF[15:6]};

  assign w_rtype   = (w_op == OP_RTYPE);
  assign w_hilo_rd = w_rtype && ((w_funct == FN_MFHI) || (w_funct == FN_MFLO));
`ifdef HAZARD_CTL_DIV_EN
  assign w_md_user = w_rtype && ((w_funct == FN_MULT) || (w_funct == FN_DIV));
`else
  assign w_md_user = w_rtype && (w_funct == FN_MULT);
`endif

  // $0 is never a real dependency, so a load into it cannot cause a stall.
  assign w_lu = MemToReg_ID && RegWrite_ID && (WriteReg_ID != 5'd0) &&
                ((WriteReg_ID == w_rs) || (WriteReg_ID == w_rt));
  assign w_md = MulDivBusy && (w_hilo_rd || w_md_user);
  assign w_mw = !DmemReady;

  assign w_req[PRIO_MW]  = w_mw;
  assign w_req[PRIO_BR]  = BranchTaken_EX;
  assign w_req[PRIO_HAZ] = w_lu || w_md;

  // A taken branch squashes the dependent instruction, so it needs no bubble;
  // a memory wait freezes everything, so neither flush nor bubble applies.
  assign AnyStall  = w_req[PRIO_MW] || (!w_req[PRIO_BR] && w_req[PRIO_HAZ]);
  assign flush     = w_req[PRIO_BR] && !w_req[PRIO_MW];
  assign Bubble_EX = !w_req[PRIO_MW] && !w_req[PRIO_BR] && w_req[PRIO_HAZ];

  muldiv_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_muldiv_seq (
    .clk        (clk),
    .reset      (reset),
    .i_is_mult  (IsMult_ID),
    .i_is_div   (IsDiv_ID),
    .i_mem_wait (w_mw),
    .o_start    (MulDivStart),
    .o_op       (MulDivOp),
    .o_busy     (MulDivBusy)
  );

endmodule : hazard_ctl

`default_nettype wire
